// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types plus the RAM responder's constants and FSM state encodings.
// The ram_responder alignment check is controlled by the RAM_ALIGN_CHECK_EN macro.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int RAM_LAT   = 2;
  localparam int RAM_DEPTH = 1024;

  localparam logic [0:0] RAM_ST_IDLE = 1'b0;
  localparam logic [0:0] RAM_ST_WAIT = 1'b1;

  // Never return a zero width, even for tiny parameter values.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ram_store_array.sv
// DEPTH x 32 word storage: one synchronous write port, one combinational read port.
// The array has no reset, so its contents survive a responder reset.
module ram_store_array
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = RAM_DEPTH,
  parameter int AW    = clog2_min1(RAM_DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  word_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output word_t         o_rdata
);

  word_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_responder.sv
// Wait-state RAM model: a held request sees LAT+1 BUSY cycles, then one ACCESS cycle.
// Build option RAM_ALIGN_CHECK_EN: a request with ramaddr[1:0] != 0 is reported as ERROR.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT   = RAM_LAT,
  parameter int DEPTH = RAM_DEPTH
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       ramREN,
  input  logic       ramWEN,
  input  word_t      ramaddr,
  input  word_t      ramstore,
  output ramstate_t  ramstate,
  output word_t      ramload,
  output logic [0:0] o_dbg_state
);

  localparam int              CW      = clog2_min1(LAT + 1);
  localparam int              AW      = clog2_min1(DEPTH);
  localparam logic [CW-1:0]   LAT_CNT = CW'(LAT);
  localparam word_t           DEPTH_W = word_t'(DEPTH);

  logic [0:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_op;    // 1 = write
  word_t         r_addr;

  logic  w_any;
  logic  w_in_range;
  logic  w_misalign;
  logic  w_err;
  logic  w_valid;
  logic  w_match;
  logic  w_access;
  logic  w_we;
  word_t w_rdata;

  assign w_any      = ramREN | ramWEN;
  assign w_in_range = ({2'b00, ramaddr[31:2]} < DEPTH_W);

`ifdef RAM_ALIGN_CHECK_EN
  assign w_misalign = (ramaddr[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err   = (ramREN & ramWEN) | ~w_in_range | w_misalign;
  assign w_valid = w_any & ~w_err;

  // Any change of op or full byte address while waiting restarts the latency.
  assign w_match  = (r_state == RAM_ST_WAIT) && (r_op == ramWEN) && (r_addr == ramaddr);
  assign w_access = ~RST & w_valid & w_match & (r_cnt == '0);
  assign w_we     = w_access & r_op;

  always_comb begin
    ramstate = FREE;
    if (!w_any) begin
      ramstate = FREE;
    end else if (w_err) begin
      ramstate = ERROR;
    end else if (w_access) begin
      ramstate = ACCESS;
    end else begin
      ramstate = BUSY;
    end
  end

  assign ramload     = (w_access && !r_op) ? w_rdata : '0;
  assign o_dbg_state = r_state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= RAM_ST_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_addr  <= '0;
    end else if (!w_valid) begin
      r_state <= RAM_ST_IDLE;
    end else if (!w_match) begin
      r_state <= RAM_ST_WAIT;
      r_cnt   <= LAT_CNT;
      r_op    <= ramWEN;
      r_addr  <= ramaddr;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CW'(1);
    end else begin
      r_state <= RAM_ST_IDLE;
    end
  end

  ram_store_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_store (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_waddr (r_addr[AW+1:2]),
    .i_wdata (ramstore),
    .i_raddr (r_addr[AW+1:2]),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: transaction-level memory model, directed scenarios and
// randomized back-to-back traffic, all checked against held-request latency rules.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;
  localparam int NFILL = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       ramREN;
  logic       ramWEN;
  word_t      ramaddr;
  word_t      ramstore;
  ramstate_t  ramstate;
  word_t      ramload;
  logic [0:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  word_t model_mem [DEPTH];

  ram_responder #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ramREN      (ramREN),
    .ramWEN      (ramWEN),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramstate    (ramstate),
    .ramload     (ramload),
    .o_dbg_state (dbg_state)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic ren, input logic wen, input word_t addr, input word_t data);
    ramREN   = ren;
    ramWEN   = wen;
    ramaddr  = addr;
    ramstore = data;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Holds one request until the first non-BUSY cycle (bounded) and reports what was seen.
  task automatic run_access(input logic ren, input logic wen, input word_t addr, input word_t data,
                            output int n_busy, output ramstate_t fin, output word_t fin_load,
                            output logic busy_leak);
    n_busy    = 0;
    busy_leak = 1'b0;
    drive(ren, wen, addr, data);
    @(negedge CLK);
    while (ramstate == BUSY && n_busy < 4 * (LAT + 2)) begin
      if (ramload !== '0) busy_leak = 1'b1;
      n_busy++;
      step();
      @(negedge CLK);
    end
    fin      = ramstate;
    fin_load = ramload;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    repeat (2) step();
    @(negedge CLK);
    n_tests++; if (ramstate !== FREE) begin n_fail++; $display("FAIL reset_free got=%0d exp=%0d", ramstate, FREE); end
    n_tests++; if (ramload !== '0) begin n_fail++; $display("FAIL reset_load got=%h exp=0", ramload); end
    n_tests++; if (dbg_state !== RAM_ST_IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    step();
    drive(1'b1, 1'b0, 32'h10, '0);
    repeat (2) step();
    @(negedge CLK);
    n_tests++; if (ramstate !== BUSY) begin n_fail++; $display("FAIL reset_req_busy got=%0d exp=%0d", ramstate, BUSY); end
    n_tests++; if (ramload !== '0) begin n_fail++; $display("FAIL reset_req_load got=%h exp=0", ramload); end
    step();
    drive(1'b1, 1'b1, 32'h10, '0);
    @(negedge CLK);
    n_tests++; if (ramstate !== ERROR) begin n_fail++; $display("FAIL reset_both_err got=%0d exp=%0d", ramstate, ERROR); end
    step();
    drive(1'b0, 1'b0, '0, '0);
    RST = 1'b0;
    step();
  endtask

  task automatic test_fill();
    int nb; ramstate_t fs; word_t fl; logic lk; word_t v;
    for (int i = 0; i < NFILL; i++) begin
      v = $urandom;
      run_access(1'b0, 1'b1, word_t'(i * 4), v, nb, fs, fl, lk);
      n_tests++; if (nb != LAT + 1) begin n_fail++; $display("FAIL fill_busy i=%0d got=%0d exp=%0d", i, nb, LAT + 1); end
      n_tests++; if (fs !== ACCESS) begin n_fail++; $display("FAIL fill_access i=%0d got=%0d exp=%0d", i, fs, ACCESS); end
      n_tests++; if (fl !== '0 || lk) begin n_fail++; $display("FAIL fill_load i=%0d got=%h leak=%0d exp=0", i, fl, lk); end
      model_mem[i] = v;
    end
    drive(1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    n_tests++; if (ramstate !== FREE) begin n_fail++; $display("FAIL fill_free got=%0d exp=%0d", ramstate, FREE); end
    step();
  endtask

  task automatic test_read_latency();
    int nb; ramstate_t fs; word_t fl; logic lk;
    for (int r = 0; r < 2; r++) begin
      run_access(1'b1, 1'b0, 32'h10, '0, nb, fs, fl, lk);
      n_tests++; if (nb != LAT + 1) begin n_fail++; $display("FAIL rd_busy r=%0d got=%0d exp=%0d", r, nb, LAT + 1); end
      n_tests++; if (fs !== ACCESS) begin n_fail++; $display("FAIL rd_access r=%0d got=%0d exp=%0d", r, fs, ACCESS); end
      n_tests++; if (fl !== model_mem[4]) begin n_fail++; $display("FAIL rd_load r=%0d got=%h exp=%h", r, fl, model_mem[4]); end
      n_tests++; if (lk) begin n_fail++; $display("FAIL rd_busy_load r=%0d got=1 exp=0", r); end
    end
    drive(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_back_to_back();
    int nb; ramstate_t fs; word_t fl; logic lk;
    run_access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, nb, fs, fl, lk);
    n_tests++; if (fs !== ACCESS || nb != LAT + 1) begin n_fail++; $display("FAIL raw_wr got=%0d/%0d exp=%0d/%0d", fs, nb, ACCESS, LAT + 1); end
    model_mem[8] = 32'hDEADBEEF;
    run_access(1'b1, 1'b0, 32'h20, '0, nb, fs, fl, lk);
    n_tests++; if (fs !== ACCESS || nb != LAT + 1) begin n_fail++; $display("FAIL raw_rd got=%0d/%0d exp=%0d/%0d", fs, nb, ACCESS, LAT + 1); end
    n_tests++; if (fl !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_load got=%h exp=deadbeef", fl); end
    drive(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_restart();
    int nb; ramstate_t fs; word_t fl; logic lk; word_t v; word_t old12;
    v = $urandom;
    old12 = model_mem[12];
    drive(1'b0, 1'b1, 32'h30, v);
    @(negedge CLK);
    n_tests++; if (ramstate !== BUSY) begin n_fail++; $display("FAIL rs_first got=%0d exp=%0d", ramstate, BUSY); end
    step();
    run_access(1'b0, 1'b1, 32'h34, v, nb, fs, fl, lk);
    n_tests++; if (nb != LAT + 1) begin n_fail++; $display("FAIL rs_busy got=%0d exp=%0d", nb, LAT + 1); end
    n_tests++; if (fs !== ACCESS) begin n_fail++; $display("FAIL rs_access got=%0d exp=%0d", fs, ACCESS); end
    model_mem[13] = v;
    run_access(1'b1, 1'b0, 32'h30, '0, nb, fs, fl, lk);
    n_tests++; if (fl !== old12) begin n_fail++; $display("FAIL rs_mem12 got=%h exp=%h", fl, old12); end
    run_access(1'b1, 1'b0, 32'h34, '0, nb, fs, fl, lk);
    n_tests++; if (fl !== v) begin n_fail++; $display("FAIL rs_mem13 got=%h exp=%h", fl, v); end
    drive(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_error();
    int nb; ramstate_t fs; word_t fl; logic lk; word_t vb;
    drive(1'b1, 1'b1, 32'h08, $urandom);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      n_tests++; if (ramstate !== ERROR || ramload !== '0) begin n_fail++; $display("FAIL err_both c=%0d got=%0d/%h exp=%0d/0", c, ramstate, ramload, ERROR); end
      step();
    end
    drive(1'b0, 1'b1, word_t'(DEPTH * 4), $urandom);
    for (int c = 0; c < LAT + 3; c++) begin
      @(negedge CLK);
      n_tests++; if (ramstate !== ERROR) begin n_fail++; $display("FAIL err_range c=%0d got=%0d exp=%0d", c, ramstate, ERROR); end
      step();
    end
    drive(1'b1, 1'b0, 32'hFFFF_FFF0, '0);
    @(negedge CLK);
    n_tests++; if (ramstate !== ERROR) begin n_fail++; $display("FAIL err_top got=%0d exp=%0d", ramstate, ERROR); end
    step();
    drive(1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    n_tests++; if (ramstate !== FREE) begin n_fail++; $display("FAIL err_free got=%0d exp=%0d", ramstate, FREE); end
    step();
    vb = $urandom;
    run_access(1'b0, 1'b1, word_t'((DEPTH - 1) * 4), vb, nb, fs, fl, lk);
    n_tests++; if (fs !== ACCESS || nb != LAT + 1) begin n_fail++; $display("FAIL err_last_wr got=%0d/%0d exp=%0d/%0d", fs, nb, ACCESS, LAT + 1); end
    model_mem[DEPTH - 1] = vb;
    run_access(1'b1, 1'b0, word_t'((DEPTH - 1) * 4), '0, nb, fs, fl, lk);
    n_tests++; if (fl !== vb) begin n_fail++; $display("FAIL err_last_rd got=%h exp=%h", fl, vb); end
    run_access(1'b1, 1'b0, 32'h08, '0, nb, fs, fl, lk);
    n_tests++; if (fl !== model_mem[2]) begin n_fail++; $display("FAIL err_mem2 got=%h exp=%h", fl, model_mem[2]); end
    run_access(1'b1, 1'b0, 32'h00, '0, nb, fs, fl, lk);
    n_tests++; if (fl !== model_mem[0]) begin n_fail++; $display("FAIL err_mem0 got=%h exp=%h", fl, model_mem[0]); end
    drive(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_reset_mid_access();
    int nb; ramstate_t fs; word_t fl; logic lk; word_t v; word_t old10;
    v = $urandom;
    drive(1'b0, 1'b1, 32'h24, v);
    @(negedge CLK);
    n_tests++; if (ramstate !== BUSY) begin n_fail++; $display("FAIL rm_busy1 got=%0d exp=%0d", ramstate, BUSY); end
    step();
    RST = 1'b1;
    @(negedge CLK);
    n_tests++; if (ramstate !== BUSY || ramload !== '0) begin n_fail++; $display("FAIL rm_rst got=%0d/%h exp=%0d/0", ramstate, ramload, BUSY); end
    step();
    RST = 1'b0;
    run_access(1'b0, 1'b1, 32'h24, v, nb, fs, fl, lk);
    n_tests++; if (nb != LAT + 1) begin n_fail++; $display("FAIL rm_relat got=%0d exp=%0d", nb, LAT + 1); end
    n_tests++; if (fs !== ACCESS) begin n_fail++; $display("FAIL rm_access got=%0d exp=%0d", fs, ACCESS); end
    model_mem[9] = v;
    // Reset lands on the cycle that would otherwise have been ACCESS.
    v = ~model_mem[10];
    old10 = model_mem[10];
    drive(1'b0, 1'b1, 32'h28, v);
    for (int c = 0; c <= LAT; c++) begin
      @(negedge CLK);
      n_tests++; if (ramstate !== BUSY) begin n_fail++; $display("FAIL rm2_busy c=%0d got=%0d exp=%0d", c, ramstate, BUSY); end
      step();
    end
    RST = 1'b1;
    @(negedge CLK);
    n_tests++; if (ramstate !== BUSY) begin n_fail++; $display("FAIL rm2_rst got=%0d exp=%0d", ramstate, BUSY); end
    step();
    RST = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    n_tests++; if (ramstate !== FREE) begin n_fail++; $display("FAIL rm2_free got=%0d exp=%0d", ramstate, FREE); end
    step();
    run_access(1'b1, 1'b0, 32'h28, '0, nb, fs, fl, lk);
    n_tests++; if (fl !== old10) begin n_fail++; $display("FAIL rm2_nowrite got=%h exp=%h", fl, old10); end
    run_access(1'b1, 1'b0, 32'h24, '0, nb, fs, fl, lk);
    n_tests++; if (fl !== model_mem[9]) begin n_fail++; $display("FAIL rm_readback got=%h exp=%h", fl, model_mem[9]); end
    drive(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_align();
    int nb; ramstate_t fs; word_t fl; logic lk;
`ifdef RAM_ALIGN_CHECK_EN
    drive(1'b1, 1'b0, 32'h11, '0);
    @(negedge CLK);
    n_tests++; if (ramstate !== ERROR) begin n_fail++; $display("FAIL align_err got=%0d exp=%0d", ramstate, ERROR); end
    step();
    nb = 0; fs = FREE; fl = '0; lk = 1'b0;
`else
    run_access(1'b1, 1'b0, 32'h11, '0, nb, fs, fl, lk);
    n_tests++; if (fs !== ACCESS || nb != LAT + 1) begin n_fail++; $display("FAIL align_acc got=%0d/%0d exp=%0d/%0d", fs, nb, ACCESS, LAT + 1); end
    n_tests++; if (fl !== model_mem[4]) begin n_fail++; $display("FAIL align_load got=%h exp=%h", fl, model_mem[4]); end
`endif
    drive(1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_random();
    int nb; ramstate_t fs; word_t fl; logic lk;
    int kind; int idx; int k; logic op; word_t v;
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, NFILL - 1);
      v    = $urandom;
      if (kind == 0 || kind == 1) begin
        if (kind == 0) drive(1'b1, 1'b1, word_t'(idx * 4), v);
        else drive(1'b0, 1'b1, word_t'((DEPTH + $urandom_range(0, 1000)) * 4), v);
        @(negedge CLK);
        n_tests++; if (ramstate !== ERROR || ramload !== '0) begin n_fail++; $display("FAIL rnd_err t=%0d got=%0d/%h exp=%0d/0", t, ramstate, ramload, ERROR); end
        step();
      end else if (kind == 2) begin
        k = $urandom_range(1, LAT + 1);
        drive(1'b0, 1'b1, word_t'(idx * 4), v);
        for (int c = 0; c < k; c++) begin
          @(negedge CLK);
          n_tests++; if (ramstate !== BUSY) begin n_fail++; $display("FAIL rnd_abort t=%0d c=%0d got=%0d exp=%0d", t, c, ramstate, BUSY); end
          step();
        end
        drive(1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        n_tests++; if (ramstate !== FREE) begin n_fail++; $display("FAIL rnd_abort_free t=%0d got=%0d exp=%0d", t, ramstate, FREE); end
        step();
      end else begin
        op = 1'($urandom_range(0, 1));
        run_access(~op, op, word_t'(idx * 4), v, nb, fs, fl, lk);
        n_tests++; if (nb != LAT + 1 || fs !== ACCESS || lk) begin n_fail++; $display("FAIL rnd_lat t=%0d got=%0d/%0d/%0d exp=%0d/%0d/0", t, nb, fs, lk, LAT + 1, ACCESS); end
        if (op) begin
          n_tests++; if (fl !== '0) begin n_fail++; $display("FAIL rnd_wr_load t=%0d got=%h exp=0", t, fl); end
          model_mem[idx] = v;
        end else begin
          n_tests++; if (fl !== model_mem[idx]) begin n_fail++; $display("FAIL rnd_rd t=%0d idx=%0d got=%h exp=%h", t, idx, fl, model_mem[idx]); end
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'b0, '0, '0);
        @(negedge CLK);
        n_tests++; if (ramstate !== FREE) begin n_fail++; $display("FAIL rnd_idle t=%0d got=%0d exp=%0d", t, ramstate, FREE); end
        step();
      end
    end
    drive(1'b0, 1'b0, '0, '0);
    step();
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    drive(1'b0, 1'b0, '0, '0);
    test_reset();
    test_fill();
    test_read_latency();
    test_back_to_back();
    test_restart();
    test_error();
    test_reset_mid_access();
    test_align();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
